// File: rtl/axi_sram_pkg.sv
// rtl/axi_sram_pkg.sv - states, response/burst/size constants for axi_sram_slave
package axi_sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    // WRAP and the reserved encoding are both rejected
    function automatic logic is_err(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_WORD) || (burst == BURST_WRAP) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/AXI_define.svh
// rtl/AXI_define.svh - AXI channel width macros shared by the SRAM slave
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH
`define AXI_IDS_BITS   8
`define AXI_ADDR_BITS  32
`define AXI_DATA_BITS  32
`define AXI_STRB_BITS  4
`define AXI_LEN_BITS   4
`define AXI_SIZE_BITS  3
`define AXI_BURST_BITS 2
`endif

// File: rtl/axi_sram_addr_gen.sv
// rtl/axi_sram_addr_gen.sv - latched SRAM word address with FIXED/INCR advance
module axi_sram_addr_gen
    import axi_sram_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [AW-1:0] i_addr,
    input  logic [1:0]    i_burst,
    input  logic          i_advance,
    output logic [AW-1:0] o_addr
);

    logic [AW-1:0] r_addr;
    logic [1:0]    r_burst;

    // Anything other than FIXED steps by one word and rolls over modulo 2^AW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_burst <= BURST_INCR;
        end else if (i_load) begin
            r_addr  <= i_addr;
            r_burst <= i_burst;
        end else if (i_advance && (r_burst != BURST_FIXED)) begin
            r_addr <= r_addr + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4 slave to single-port SRAM bridge; SLVERR checking under AXI_SRAM_SLVERR_EN
`include "AXI_define.svh"
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int SRAM_AW = 14,
    parameter int IDW     = `AXI_IDS_BITS
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic [IDW-1:0]              ARID,
    input  logic [`AXI_ADDR_BITS-1:0]   ARADDR,
    input  logic [`AXI_LEN_BITS-1:0]    ARLEN,
    input  logic [`AXI_SIZE_BITS-1:0]   ARSIZE,
    input  logic [`AXI_BURST_BITS-1:0]  ARBURST,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    output logic [IDW-1:0]              RID,
    output logic [`AXI_DATA_BITS-1:0]   RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RLAST,
    output logic                        RVALID,
    input  logic                        RREADY,
    input  logic [IDW-1:0]              AWID,
    input  logic [`AXI_ADDR_BITS-1:0]   AWADDR,
    input  logic [`AXI_LEN_BITS-1:0]    AWLEN,
    input  logic [`AXI_SIZE_BITS-1:0]   AWSIZE,
    input  logic [`AXI_BURST_BITS-1:0]  AWBURST,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [`AXI_DATA_BITS-1:0]   WDATA,
    input  logic [`AXI_STRB_BITS-1:0]   WSTRB,
    input  logic                        WLAST,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic [IDW-1:0]              BID,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    output logic                        SRAM_CS,
    output logic                        SRAM_OE,
    output logic [3:0]                  SRAM_WEB,
    output logic [SRAM_AW-1:0]          SRAM_A,
    output logic [31:0]                 SRAM_DI,
    input  logic [31:0]                 SRAM_DO
);

    state_t                     r_state, w_next;
    logic                       r_prio;
    logic [IDW-1:0]             r_id;
    logic [`AXI_LEN_BITS-1:0]   r_len, r_cnt;
    logic [31:0]                r_rdata;
    logic                       r_hold;
    logic                       w_err;
    logic                       w_idle, w_ar_go, w_aw_go, w_r_fire, w_w_fire, w_rlast, w_adv;
    logic [SRAM_AW-1:0]         w_addr;
    logic [31:0]                w_rdata_src;
    logic                       w_unused;

    // r_prio: 0 lets a read win a tie, 1 lets a write win
    assign w_idle   = (r_state == IDLE) & ARESETn;
    assign w_ar_go  = w_idle & ARVALID & (!AWVALID | !r_prio);
    assign w_aw_go  = w_idle & AWVALID & (!ARVALID | r_prio);
    assign w_r_fire = (r_state == RD_DATA) & RREADY;
    assign w_w_fire = (r_state == WR_DATA) & WVALID;
    assign w_rlast  = (r_cnt == r_len);
    assign w_adv    = (w_r_fire & !w_rlast) | w_w_fire;

`ifdef AXI_SRAM_SLVERR_EN
    logic r_err;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_err <= 1'b0;
        end else if (w_ar_go) begin
            r_err <= is_err(ARSIZE, ARBURST);
        end else if (w_aw_go) begin
            r_err <= is_err(AWSIZE, AWBURST);
        end
    end

    assign w_err = r_err;
`else
    assign w_err = 1'b0;
`endif

    assign w_unused = ^{AWLEN, ARSIZE, AWSIZE,
                        ARADDR[`AXI_ADDR_BITS-1:SRAM_AW+2], ARADDR[1:0],
                        AWADDR[`AXI_ADDR_BITS-1:SRAM_AW+2], AWADDR[1:0]};

    axi_sram_addr_gen #(
        .AW (SRAM_AW)
    ) u_addr_gen (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .i_load    (w_ar_go | w_aw_go),
        .i_addr    (w_ar_go ? ARADDR[SRAM_AW+1:2] : AWADDR[SRAM_AW+1:2]),
        .i_burst   (w_ar_go ? ARBURST : AWBURST),
        .i_advance (w_adv),
        .o_addr    (w_addr)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hold  <= (r_state == RD_DATA) & !RREADY;
            if (w_ar_go) begin
                r_id   <= ARID;
                r_len  <= ARLEN;
                r_cnt  <= '0;
                r_prio <= ~r_prio;
            end else if (w_aw_go) begin
                r_id   <= AWID;
                r_prio <= ~r_prio;
            end
            if ((r_state == RD_DATA) && !r_hold) begin
                r_rdata <= w_rdata_src;
            end
            if (w_r_fire && !w_rlast) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // SRAM_DO is only valid in the first RD_DATA cycle; later stall cycles replay the capture
    assign w_rdata_src = w_err ? 32'h0 : SRAM_DO;
    assign RDATA       = ((r_state == RD_DATA) && !r_hold) ? w_rdata_src : r_rdata;
    assign RID         = r_id;
    assign BID         = r_id;
    assign RRESP       = w_err ? RESP_SLVERR : RESP_OKAY;
    assign BRESP       = w_err ? RESP_SLVERR : RESP_OKAY;
    assign SRAM_A      = w_addr;

    always_comb begin
        w_next   = r_state;
        ARREADY  = w_ar_go;
        AWREADY  = w_aw_go;
        WREADY   = 1'b0;
        RVALID   = 1'b0;
        RLAST    = 1'b0;
        BVALID   = 1'b0;
        SRAM_CS  = 1'b0;
        SRAM_OE  = 1'b0;
        SRAM_WEB = 4'hF;
        SRAM_DI  = 32'h0;
        case (r_state)
            IDLE: begin
                if (w_ar_go) begin
                    w_next = RD_REQ;
                end else if (w_aw_go) begin
                    w_next = WR_DATA;
                end
            end
            RD_REQ: begin
                SRAM_CS = !w_err;
                SRAM_OE = !w_err;
                w_next  = RD_DATA;
            end
            RD_DATA: begin
                RVALID = 1'b1;
                RLAST  = w_rlast;
                if (w_r_fire) begin
                    w_next = w_rlast ? IDLE : RD_REQ;
                end
            end
            WR_DATA: begin
                WREADY = 1'b1;
                if (w_w_fire) begin
                    if (!w_err) begin
                        SRAM_CS  = 1'b1;
                        SRAM_WEB = ~WSTRB;
                        SRAM_DI  = WDATA;
                    end
                    if (WLAST) begin
                        w_next = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                BVALID = 1'b1;
                if (BREADY) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed self-checking bench for axi_sram_slave
module tb_axi_sram_slave;
    import axi_sram_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [7:0]  ARID, AWID, RID, BID;
    logic [31:0] ARADDR, AWADDR, RDATA, WDATA, SRAM_DI, SRAM_DO;
    logic [3:0]  ARLEN, AWLEN, WSTRB, SRAM_WEB;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, AWVALID, AWREADY;
    logic        WLAST, WVALID, WREADY, BVALID, BREADY, SRAM_CS, SRAM_OE;
    logic [13:0] SRAM_A;

    logic [31:0] mem [0:16383];
    logic [13:0] rd_addr_q[$];
    logic [49:0] wr_log_q[$];
    int          cs_count = 0;
    int          tests = 0;
    int          fails = 0;

    logic [31:0] rd_data [0:15];
    logic [1:0]  rd_resp [0:15];
    logic        rd_last [0:15];
    logic [7:0]  rd_id   [0:15];
    logic        stall_changed;

    always #5 ACLK = ~ACLK;

    axi_sram_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .SRAM_CS(SRAM_CS), .SRAM_OE(SRAM_OE), .SRAM_WEB(SRAM_WEB), .SRAM_A(SRAM_A),
        .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
    );

    // Registered-read SRAM model; writes are logged rather than stored
    always @(posedge ACLK) begin
        if (SRAM_CS) begin
            cs_count <= cs_count + 1;
            if (SRAM_OE) begin
                SRAM_DO <= mem[SRAM_A];
                rd_addr_q.push_back(SRAM_A);
            end
            if (SRAM_WEB != 4'hF) wr_log_q.push_back({SRAM_A, SRAM_WEB, SRAM_DI});
        end
    end

    task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, output bit ok);
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = 3'b010; ARVALID = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge ACLK);
            if (ARREADY) ok = 1'b1;
            @(posedge ACLK); #1;
        end
        ARVALID = 1'b0;
    endtask

    task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, output bit ok);
        AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = 3'b010; AWVALID = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge ACLK);
            if (AWREADY) ok = 1'b1;
            @(posedge ACLK); #1;
        end
        AWVALID = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last, output bit ok);
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge ACLK);
            if (WREADY) ok = 1'b1;
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic b_wait(input int hold, output bit ok, output logic [7:0] bid, output bit held);
        ok = 1'b0; held = 1'b1; bid = 8'h00;
        for (int c = 0; c < 50; c++) begin
            @(negedge ACLK);
            if (BVALID) begin ok = 1'b1; break; end
        end
        bid = BID;
        for (int c = 0; c < hold; c++) begin
            @(negedge ACLK);
            if (!BVALID || BID !== bid) held = 1'b0;
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic r_collect(input int nbeats, input int stall_beat, input int stall_cyc, output bit ok);
        int got = 0;
        int st = 0;
        logic [31:0] stall_val = 32'h0;
        stall_changed = 1'b0;
        for (int c = 0; c < 100 && got < nbeats; c++) begin
            @(negedge ACLK);
            if (RVALID) begin
                if (got == stall_beat && st < stall_cyc) begin
                    if (st == 0) stall_val = RDATA;
                    else if (RDATA !== stall_val) stall_changed = 1'b1;
                    RREADY = 1'b0;
                    st++;
                end else begin
                    if (st > 0 && got == stall_beat && RDATA !== stall_val) stall_changed = 1'b1;
                    rd_data[got] = RDATA; rd_resp[got] = RRESP; rd_last[got] = RLAST; rd_id[got] = RID;
                    RREADY = 1'b1;
                    got++;
                end
            end
        end
        @(posedge ACLK); #1;
        RREADY = 1'b0;
        ok = (got == nbeats);
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        ARVALID = 1'b1; AWVALID = 1'b1; WVALID = 1'b0; RREADY = 1'b0; BREADY = 1'b0; WLAST = 1'b0;
        ARID = 8'h0; ARADDR = 32'h0; ARLEN = 4'h0; ARSIZE = 3'b010; ARBURST = 2'b01;
        AWID = 8'h0; AWADDR = 32'h0; AWLEN = 4'h0; AWSIZE = 3'b010; AWBURST = 2'b01;
        WDATA = 32'h0; WSTRB = 4'h0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        tests++;
        if ({ARREADY, AWREADY, WREADY, RVALID, BVALID, RLAST} !== 6'b0) begin
            fails++; $display("FAIL reset_handshake: got %b exp 000000", {ARREADY, AWREADY, WREADY, RVALID, BVALID, RLAST});
        end
        tests++;
        if ({RDATA, RID, BID, RRESP, BRESP} !== 52'h0) begin
            fails++; $display("FAIL reset_resp: RDATA=%h RID=%h BID=%h RRESP=%b BRESP=%b exp all 0", RDATA, RID, BID, RRESP, BRESP);
        end
        tests++;
        if ({SRAM_CS, SRAM_OE, SRAM_WEB, SRAM_A} !== {2'b00, 4'hF, 14'h0}) begin
            fails++; $display("FAIL reset_sram: CS=%b OE=%b WEB=%b A=%h exp 0 0 1111 0", SRAM_CS, SRAM_OE, SRAM_WEB, SRAM_A);
        end
        tests++;
        if (dut.r_state !== IDLE || dut.r_prio !== 1'b0) begin
            fails++; $display("FAIL reset_fsm: state=%0d prio=%b exp IDLE/0", dut.r_state, dut.r_prio);
        end
        ARVALID = 1'b0; AWVALID = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
    endtask

    task automatic test_simultaneous();
        bit ok, held;
        logic [7:0] bid;
        for (int round = 0; round < 3; round++) begin
            ARID = 8'h11; ARADDR = 32'h10; ARLEN = 4'h0; ARBURST = 2'b01; ARVALID = 1'b1;
            AWID = 8'h22; AWADDR = 32'h30; AWLEN = 4'h0; AWBURST = 2'b01; AWVALID = 1'b1;
            @(negedge ACLK);
            tests++;
            if ({ARREADY, AWREADY} !== ((round == 2) ? 2'b01 : 2'b10)) begin
                fails++; $display("FAIL simul_grant_r%0d: AR/AW ready=%b exp %b", round, {ARREADY, AWREADY}, (round == 2) ? 2'b01 : 2'b10);
            end
            @(posedge ACLK); #1;
            if (round == 2) begin
                AWVALID = 1'b0;
                w_beat(32'hCAFE_0002, 4'hF, 1'b1, ok);
                b_wait(0, ok, bid, held);
                ar_send(8'h11, 32'h10, 4'h0, 2'b01, ok);
                r_collect(1, -1, 0, ok);
            end else begin
                ARVALID = 1'b0;
                r_collect(1, -1, 0, ok);
                tests++;
                if (!ok || rd_id[0] !== 8'h11 || rd_data[0] !== 32'hDEADBEEF) begin
                    fails++; $display("FAIL simul_read_r%0d: ok=%b RID=%h RDATA=%h exp 11 deadbeef", round, ok, rd_id[0], rd_data[0]);
                end
                if (round == 1) begin
                    AWVALID = 1'b0;
                end else begin
                    aw_send(8'h22, 32'h30, 4'h0, 2'b01, ok);
                    w_beat(32'hCAFE_0001, 4'hF, 1'b1, ok);
                    b_wait(0, ok, bid, held);
                    tests++;
                    if (!ok || bid !== 8'h22) begin
                        fails++; $display("FAIL simul_write: ok=%b BID=%h exp 22", ok, bid);
                    end
                end
            end
        end
    endtask

    task automatic test_single_read();
        bit ok;
        ar_send(8'h05, 32'h0000_0010, 4'h0, 2'b01, ok);
        @(negedge ACLK);
        tests++;
        if (!ok || SRAM_A !== 14'd4 || SRAM_CS !== 1'b1 || SRAM_OE !== 1'b1 || RVALID !== 1'b0) begin
            fails++; $display("FAIL single_req: ok=%b A=%h CS=%b OE=%b RVALID=%b exp A=4 CS=1 OE=1 RVALID=0", ok, SRAM_A, SRAM_CS, SRAM_OE, RVALID);
        end
        @(negedge ACLK);
        tests++;
        if ({RVALID, RDATA, RID, RLAST, RRESP} !== {1'b1, 32'hDEADBEEF, 8'h05, 1'b1, 2'b00}) begin
            fails++; $display("FAIL single_data: RVALID=%b RDATA=%h RID=%h RLAST=%b RRESP=%b exp 1 deadbeef 05 1 00", RVALID, RDATA, RID, RLAST, RRESP);
        end
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
        @(negedge ACLK);
        tests++;
        if (RVALID !== 1'b0) begin
            fails++; $display("FAIL single_done: RVALID=%b exp 0", RVALID);
        end
    endtask

    task automatic test_incr_burst_wrap();
        bit ok;
        rd_addr_q.delete();
        ar_send(8'h07, 32'h0000_FFF8, 4'h3, 2'b01, ok);
        r_collect(4, 1, 3, ok);
        tests++;
        if (!ok || rd_addr_q.size() != 4) begin
            fails++; $display("FAIL burst_count: ok=%b addr reqs=%0d exp 4", ok, rd_addr_q.size());
        end else if ({rd_addr_q[0], rd_addr_q[1], rd_addr_q[2], rd_addr_q[3]} !== {14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001}) begin
            fails++; $display("FAIL burst_addr: got %h %h %h %h exp 3ffe 3fff 0000 0001", rd_addr_q[0], rd_addr_q[1], rd_addr_q[2], rd_addr_q[3]);
        end
        tests++;
        if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== {32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004}) begin
            fails++; $display("FAIL burst_data: got %h %h %h %h exp a0000001..a0000004", rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
        end
        tests++;
        if ({rd_last[0], rd_last[1], rd_last[2], rd_last[3]} !== 4'b0001 || stall_changed !== 1'b0) begin
            fails++; $display("FAIL burst_last_stall: RLAST seq=%b stall_changed=%b exp 0001 0",
                              {rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, stall_changed);
        end
    endtask

    task automatic test_write_burst();
        bit ok, ok2, held;
        logic [7:0] bid;
        wr_log_q.delete();
        aw_send(8'h3C, 32'h0000_0020, 4'h1, 2'b01, ok);
        w_beat(32'h1111_2222, 4'b0011, 1'b0, ok);
        w_beat(32'h3333_4444, 4'b1111, 1'b1, ok2);
        @(negedge ACLK);
        tests++;
        if (!ok || !ok2 || BVALID !== 1'b1 || BID !== 8'h3C || BRESP !== 2'b00) begin
            fails++; $display("FAIL wr_bvalid: ok=%b%b BVALID=%b BID=%h BRESP=%b exp 1 3c 00", ok, ok2, BVALID, BID, BRESP);
        end
        b_wait(3, ok, bid, held);
        tests++;
        if (!ok || !held || bid !== 8'h3C) begin
            fails++; $display("FAIL wr_bhold: ok=%b held=%b BID=%h exp 1 1 3c", ok, held, bid);
        end
        tests++;
        if (wr_log_q.size() != 2) begin
            fails++; $display("FAIL wr_count: got %0d writes exp 2", wr_log_q.size());
        end else if (wr_log_q[0] !== {14'd8, 4'b1100, 32'h1111_2222} || wr_log_q[1] !== {14'd9, 4'b0000, 32'h3333_4444}) begin
            fails++; $display("FAIL wr_beats: got %h %h exp A=8 WEB=1100, A=9 WEB=0000", wr_log_q[0], wr_log_q[1]);
        end
        @(negedge ACLK);
        tests++;
        if (BVALID !== 1'b0) begin
            fails++; $display("FAIL wr_bdone: BVALID=%b exp 0", BVALID);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok, seen;
        ar_send(8'h44, 32'h0000_0100, 4'h3, 2'b01, ok);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge ACLK);
            if (RVALID) seen = 1'b1;
        end
        ARESETn = 1'b0;
        #1;
        tests++;
        if (!seen || RVALID !== 1'b0 || dut.r_state !== IDLE) begin
            fails++; $display("FAIL rst_mid: seen=%b RVALID=%b state=%0d exp 1 0 IDLE", seen, RVALID, dut.r_state);
        end
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        ar_send(8'h06, 32'h0000_0010, 4'h0, 2'b01, ok);
        r_collect(1, -1, 0, ok);
        tests++;
        if (!ok || {rd_data[0], rd_id[0], rd_last[0], rd_resp[0]} !== {32'hDEADBEEF, 8'h06, 1'b1, 2'b00}) begin
            fails++; $display("FAIL rst_after: ok=%b RDATA=%h RID=%h RLAST=%b RRESP=%b exp deadbeef 06 1 00", ok, rd_data[0], rd_id[0], rd_last[0], rd_resp[0]);
        end
    endtask

    task automatic test_slverr();
        bit ok;
        int cs0;
        logic [31:0] exp_d0, exp_d1;
        logic [1:0]  exp_resp;
        int          exp_cs;
`ifdef AXI_SRAM_SLVERR_EN
        exp_d0 = 32'h0; exp_d1 = 32'h0; exp_resp = 2'b10; exp_cs = 0;
`else
        exp_d0 = 32'hC0DE0010; exp_d1 = 32'hC0DE0011; exp_resp = 2'b00; exp_cs = 2;
`endif
        cs0 = cs_count;
        ar_send(8'h33, 32'h0000_0040, 4'h1, 2'b10, ok);
        r_collect(2, -1, 0, ok);
        tests++;
        if (!ok || rd_data[0] !== exp_d0 || rd_data[1] !== exp_d1) begin
            fails++; $display("FAIL wrapburst_data: ok=%b got %h %h exp %h %h", ok, rd_data[0], rd_data[1], exp_d0, exp_d1);
        end
        tests++;
        if (rd_resp[0] !== exp_resp || rd_resp[1] !== exp_resp || {rd_last[0], rd_last[1]} !== 2'b01) begin
            fails++; $display("FAIL wrapburst_resp: RRESP %b %b RLAST %b%b exp %b 01", rd_resp[0], rd_resp[1], rd_last[0], rd_last[1], exp_resp);
        end
        tests++;
        if (cs_count - cs0 != exp_cs) begin
            fails++; $display("FAIL wrapburst_cs: SRAM_CS cycles %0d exp %0d", cs_count - cs0, exp_cs);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[4]        = 32'hDEADBEEF;
        mem[14'h3FFE] = 32'hA0000001;
        mem[14'h3FFF] = 32'hA0000002;
        mem[0]        = 32'hA0000003;
        mem[1]        = 32'hA0000004;
        mem[16]       = 32'hC0DE0010;
        mem[17]       = 32'hC0DE0011;
        test_reset();
        test_simultaneous();
        test_single_read();
        test_incr_burst_wrap();
        test_write_burst();
        test_reset_mid_burst();
        test_slverr();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 responder that bridges one interconnect slave port to a single-port synchronous SRAM macro.
- Sits on the slave side of the interconnect. It produces the AR/AW/W ready signals and the R and B responses that the interconnect's slave-to-master path forwards to masters.
- Serves one transaction at a time, either read or write. Each beat is one 32-bit word.

Parameters:
- SRAM_AW, 14, SRAM word-address width (64 KB region). SRAM address is taken from AxADDR[SRAM_AW+1:2].
- IDW, `AXI_IDS_BITS (8), slave-side ID width.

Ports:
- ACLK  in  1  clock; all state updates on rising edge.
- ARESETn  in  1  reset, asynchronous, active-low.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  IDW/32/4/3/2/1  read address channel.
- ARREADY  out  1  read address accept.
- RID/RDATA/RRESP/RLAST/RVALID  out  IDW/32/2/1/1  read data channel.
- RREADY  in  1  read data accept.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  IDW/32/4/3/2/1  write address channel.
- AWREADY  out  1  write address accept.
- WDATA/WSTRB/WLAST/WVALID  in  32/4/1/1  write data channel.
- WREADY  out  1  write data accept.
- BID/BRESP/BVALID  out  IDW/2/1  write response channel.
- BREADY  in  1  write response accept.
- SRAM_CS  out  1  chip select.
- SRAM_OE  out  1  read enable.
- SRAM_WEB  out  4  byte write enables, active-low.
- SRAM_A  out  SRAM_AW  word address.
- SRAM_DI  out  32  write data.
- SRAM_DO  in  32  read data, valid one cycle after a read request.

Behaviour:
- Reset state and outputs while ARESETn=0:
  - FSM in IDLE; prio=RD.
  - All ready and valid outputs 0.
  - RDATA, RID, BID and SRAM_A at 0; RRESP/BRESP=OKAY.
  - SRAM_CS=0, SRAM_OE=0, SRAM_WEB=4'hF.
- Reset mid-burst: transaction is abandoned, no response issued. After release the FSM starts in IDLE.
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
- IDLE:
  - ARREADY = ARVALID & (!AWVALID | prio==RD).
  - AWREADY = AWVALID & (!ARVALID | prio==WR).
  - prio flips after every granted transaction. Simultaneous AR/AW therefore alternate between read and write.
- AR handshake:
  - Latch ARID, word address, ARLEN and ARBURST; beat counter cnt=0.
  - Next state RD_REQ.
- RD_REQ (1 cycle):
  - SRAM_CS=1, SRAM_OE=1, SRAM_A=addr.
  - Next state RD_DATA. SRAM_DO is captured into the RDATA register on entry to RD_DATA.
- RD_DATA:
  - RVALID=1; RID and RDATA held stable while RREADY=0.
  - RLAST = (cnt==len).
  - On RREADY: if RLAST go to IDLE; else cnt++, address advances, go to RD_REQ.
  - Read throughput is one beat per 2 cycles. First RVALID is 2 cycles after the AR handshake.
- AW handshake:
  - Latch AWID, word address and AWBURST.
  - Next state WR_DATA.
- WR_DATA:
  - WREADY=1.
  - On WVALID: SRAM_CS=1, SRAM_WEB=~WSTRB, SRAM_A=addr, SRAM_DI=WDATA in the same cycle; address advances.
  - Burst ends on the beat with WLAST=1, then go to WR_RESP. AWLEN is not used to terminate.
- WR_RESP:
  - BVALID=1; BID held.
  - On BREADY go to IDLE.
- Address advance:
  - FIXED (2'b00): address unchanged.
  - INCR (2'b01), and WRAP/reserved when the optional feature is out: word address +1.
  - Word address wraps modulo 2^SRAM_AW, e.g. 0x3FFF→0x0000.
- No new AR or AW is accepted outside IDLE.

Optional Feature:
- Macro name: AXI_SRAM_SLVERR_EN.
- Defined: a transaction is erroneous if AxSIZE≠3'b010 or AxBURST∈{2'b10, 2'b11}, decided at address handshake. Erroneous transactions:
  - handshake normally and return the full beat count (reads: len+1 beats; writes: until WLAST);
  - make no SRAM access (SRAM_CS=0, SRAM_WEB=4'hF);
  - return RDATA=0 with RRESP=SLVERR (2'b10) on every beat, or BRESP=SLVERR.
- Undefined: AxSIZE is ignored, WRAP/reserved bursts behave as INCR, and RRESP/BRESP are always OKAY.

Decomposition:
- Package axi_sram_pkg holds:
  - state enum (IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP);
  - RESP constants (OKAY=2'b00, SLVERR=2'b10);
  - BURST constants (FIXED, INCR, WRAP);
  - SIZE_WORD=3'b010.
- Width macros come from AXI_define.svh.
- One sub-module, axi_sram_addr_gen: holds the latched word address and burst type. Inputs are load/advance; output is the current address, with the wrap rule above.

Test Plan:
- Single read: ARADDR=0x0000_0010, ARLEN=0, INCR, ARID=8'h05; SRAM word 4 preloaded with 0xDEADBEEF → SRAM_A=4 one cycle after handshake; RVALID two cycles after with RDATA=0xDEADBEEF, RID=8'h05, RLAST=1, RRESP=OKAY.
- INCR read burst ARLEN=3 from 0x0000_FFF8 with RREADY low for 3 cycles on beat 1 → SRAM_A sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001; RDATA stable while stalled; RLAST only on beat 4.
- Write burst AWLEN=1 to 0x0000_0020, WSTRB 4'b0011 then 4'b1111 → SRAM_WEB 4'b1100 at A=8, then 4'b0000 at A=9; BVALID after WLAST beat with BID=AWID; BVALID held until BREADY.
- Simultaneous ARVALID and AWVALID, both held, with prio=RD after reset → read served first, then write; repeat of both → read first again (prio alternates per granted transaction).
- ARESETn asserted during RD_DATA of a 4-beat burst → RVALID=0 and FSM in IDLE immediately; after release, a new single read completes normally.
- With AXI_SRAM_SLVERR_EN defined: ARBURST=2'b10, ARLEN=1 → 2 beats, RDATA=0, RRESP=2'b10, SRAM_CS never 1. Same stimulus without the macro → 2 beats from consecutive words with RRESP=OKAY.
